// File: rtl/eeprom_pkg.sv
// Shared opcodes, FSM encoding and timing defaults for the EEPROM transfer controller.
package eeprom_pkg;

  localparam logic [1:0] IIC_OP_IDLE = 2'b00;
  localparam logic [1:0] IIC_OP_WR   = 2'b01;
  localparam logic [1:0] IIC_OP_RD   = 2'b10;

  // 5 ms write cycle at 50 MHz
  localparam int TWR_CYCLES_DEFAULT = 250000;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_WDATA = 3'd1,
    ST_WR_ISSUE   = 3'd2,
    ST_WR_TWR     = 3'd3,
    ST_RD_ISSUE   = 3'd4,
    ST_RD_GAP     = 3'd5,
    ST_DONE       = 3'd6
  } state_t;

  function automatic int twr_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/eeprom_twr_timer.sv
// Loadable down-counter that times the EEPROM internal write cycle.
module eeprom_twr_timer
  import eeprom_pkg::*;
#(
  parameter int TWR_CYCLES = TWR_CYCLES_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  output logic zero
);

  localparam int W = twr_width(TWR_CYCLES);
  localparam logic [W-1:0] LOAD_VAL = W'(TWR_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/eeprom_xfer_ctrl.sv
// Breaks a multi-byte EEPROM read/write request into single-byte iic_com operations.
module eeprom_xfer_ctrl
  import eeprom_pkg::*;
#(
  parameter int TWR_CYCLES = TWR_CYCLES_DEFAULT,
  parameter int LEN_W      = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Req_Valid,
  output logic             Req_Ready,
  input  logic             Req_Write,
  input  logic [7:0]       Req_Addr,
  input  logic [LEN_W-1:0] Req_Len,
  input  logic [7:0]       Wr_Data,
  input  logic             Wr_Valid,
  output logic             Wr_Ready,
  output logic [7:0]       Rd_Data,
  output logic             Rd_Valid,
  output logic             Busy,
  output logic             Xfer_Done,
  output logic [1:0]       Start_Sig,
  output logic [7:0]       Addr_Sig,
  output logic [7:0]       WrData,
  input  logic [7:0]       RdData,
  input  logic             Done_Sig,
  output state_t           dbg_state
);

  // Handshakes: a transfer happens on a cycle where valid && ready; Rd_Valid has no backpressure.
  state_t           state, state_nx;
  logic [7:0]       addr, addr_nx;
  logic [LEN_W-1:0] cnt, cnt_nx;
  logic [1:0]       start_nx;
  logic [7:0]       addr_sig_nx, wrdata_nx, rd_data_nx;
  logic             rd_valid_nx, xfer_done_nx;
  logic             tmr_load, tmr_zero;

  eeprom_twr_timer #(.TWR_CYCLES(TWR_CYCLES)) u_twr_timer (
    .CLK  (CLK),
    .RST  (RST),
    .load (tmr_load),
    .zero (tmr_zero)
  );

  always_comb begin
    state_nx     = state;
    addr_nx      = addr;
    cnt_nx       = cnt;
    start_nx     = Start_Sig;
    addr_sig_nx  = Addr_Sig;
    wrdata_nx    = WrData;
    rd_data_nx   = Rd_Data;
    rd_valid_nx  = 1'b0;
    xfer_done_nx = 1'b0;
    tmr_load     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Req_Valid && Req_Ready) begin
          addr_nx = Req_Addr;
          cnt_nx  = Req_Len;
          if (Req_Write) begin
            state_nx = ST_WAIT_WDATA;
          end else begin
            state_nx    = ST_RD_ISSUE;
            start_nx    = IIC_OP_RD;
            addr_sig_nx = Req_Addr;
          end
        end
      end
      ST_WAIT_WDATA: begin
        if (Wr_Valid && Wr_Ready) begin
          wrdata_nx   = Wr_Data;
          addr_sig_nx = addr;
          start_nx    = IIC_OP_WR;
          state_nx    = ST_WR_ISSUE;
        end
      end
      ST_WR_ISSUE: begin
        if (Done_Sig) begin
          start_nx = IIC_OP_IDLE;
          tmr_load = 1'b1;
          state_nx = ST_WR_TWR;
        end
      end
      ST_WR_TWR: begin
        // Timer was loaded with TWR_CYCLES-1, so this state lasts exactly TWR_CYCLES cycles
        if (tmr_zero) begin
          if (cnt == '0) begin
            state_nx = ST_DONE;
          end else begin
            addr_nx  = addr + 8'd1;
            cnt_nx   = cnt - LEN_W'(1);
            state_nx = ST_WAIT_WDATA;
          end
        end
      end
      ST_RD_ISSUE: begin
        if (Done_Sig) begin
          rd_data_nx  = RdData;
          rd_valid_nx = 1'b1;
          start_nx    = IIC_OP_IDLE;
          state_nx    = ST_RD_GAP;
        end
      end
      ST_RD_GAP: begin
        if (cnt == '0) begin
          state_nx = ST_DONE;
        end else begin
          addr_nx     = addr + 8'd1;
          cnt_nx      = cnt - LEN_W'(1);
          addr_sig_nx = addr + 8'd1;
          start_nx    = IIC_OP_RD;
          state_nx    = ST_RD_ISSUE;
        end
      end
      ST_DONE: begin
        xfer_done_nx = 1'b1;
        state_nx     = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      addr      <= '0;
      cnt       <= '0;
      Start_Sig <= IIC_OP_IDLE;
      Addr_Sig  <= '0;
      WrData    <= '0;
      Rd_Data   <= '0;
      Rd_Valid  <= 1'b0;
      Xfer_Done <= 1'b0;
      Busy      <= 1'b0;
      Wr_Ready  <= 1'b0;
      Req_Ready <= 1'b1;
    end else begin
      state     <= state_nx;
      addr      <= addr_nx;
      cnt       <= cnt_nx;
      Start_Sig <= start_nx;
      Addr_Sig  <= addr_sig_nx;
      WrData    <= wrdata_nx;
      Rd_Data   <= rd_data_nx;
      Rd_Valid  <= rd_valid_nx;
      Xfer_Done <= xfer_done_nx;
      Busy      <= (state_nx != ST_IDLE);
      Wr_Ready  <= (state_nx == ST_WAIT_WDATA);
      Req_Ready <= (state_nx == ST_IDLE);
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_eeprom_xfer_ctrl.sv
// Directed bench for eeprom_xfer_ctrl with a behavioural iic_com stand-in (20-cycle op latency).
module tb_eeprom_xfer_ctrl;
  import eeprom_pkg::*;

  logic       CLK, RST;
  logic       Req_Valid, Req_Ready, Req_Write;
  logic [7:0] Req_Addr, Req_Len;
  logic [7:0] Wr_Data;
  logic       Wr_Valid, Wr_Ready;
  logic [7:0] Rd_Data;
  logic       Rd_Valid, Busy, Xfer_Done;
  logic [1:0] Start_Sig;
  logic [7:0] Addr_Sig, WrData, RdData;
  logic       Done_Sig;
  state_t     dbg_state;

  int errors = 0;
  int checks = 0;

  // iic_com stand-in
  int         m_phase = 0;
  int         m_cnt = 0;
  logic       m_done = 1'b0;
  logic [7:0] m_rd = 8'h00;
  logic       spur_done = 1'b0;

  // scoreboard / monitors
  logic [7:0] exp_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] addr_q[$];
  logic [7:0] wd_q[$];
  int op_cnt = 0, rv_cnt = 0, xd_cnt = 0, dbl_cnt = 0;
  int cyc = 0, last_rv = 0, last_xd = 0;
  logic [1:0] prev_start = 2'b00;
  logic prev_rv = 1'b0, prev_xd = 1'b0;

  eeprom_xfer_ctrl #(.TWR_CYCLES(16), .LEN_W(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Req_Valid (Req_Valid),
    .Req_Ready (Req_Ready),
    .Req_Write (Req_Write),
    .Req_Addr  (Req_Addr),
    .Req_Len   (Req_Len),
    .Wr_Data   (Wr_Data),
    .Wr_Valid  (Wr_Valid),
    .Wr_Ready  (Wr_Ready),
    .Rd_Data   (Rd_Data),
    .Rd_Valid  (Rd_Valid),
    .Busy      (Busy),
    .Xfer_Done (Xfer_Done),
    .Start_Sig (Start_Sig),
    .Addr_Sig  (Addr_Sig),
    .WrData    (WrData),
    .RdData    (RdData),
    .Done_Sig  (Done_Sig),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  assign Done_Sig = m_done | spur_done;
  assign RdData   = m_rd;

  always @(posedge CLK) begin
    if (RST) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_done  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      case (m_phase)
        0: if (Start_Sig != 2'b00) begin
             m_phase <= 1;
             m_cnt   <= 1;
           end
        1: if (m_cnt == 20) begin
             m_done  <= 1'b1;
             m_rd    <= Addr_Sig ^ 8'hA5;
             m_phase <= 2;
           end else begin
             m_cnt <= m_cnt + 1;
           end
        default: if (Start_Sig == 2'b00) m_phase <= 0;
      endcase
    end
  end

  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      prev_start = 2'b00;
      prev_rv    = 1'b0;
      prev_xd    = 1'b0;
    end else begin
      if (Start_Sig != 2'b00 && prev_start == 2'b00) begin
        op_cnt++;
        addr_q.push_back(Addr_Sig);
        wd_q.push_back(WrData);
      end
      if (Rd_Valid) begin
        rv_cnt++;
        rd_q.push_back(Rd_Data);
        last_rv = cyc;
        if (prev_rv) dbl_cnt++;
      end
      if (Xfer_Done) begin
        xd_cnt++;
        last_xd = cyc;
        if (prev_xd) dbl_cnt++;
      end
      prev_start = Start_Sig;
      prev_rv    = Rd_Valid;
      prev_xd    = Xfer_Done;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    op_cnt = 0;
    rv_cnt = 0;
    xd_cnt = 0;
    addr_q.delete();
    wd_q.delete();
    rd_q.delete();
    exp_q.delete();
  endtask

  task automatic send_req(input logic w, input logic [7:0] a, input logic [7:0] l);
    int n;
    n = 0;
    while (!Req_Ready && n < 200) begin
      tick();
      n++;
    end
    check("req_ready_before_req", Req_Ready, 1);
    Req_Valid = 1'b1;
    Req_Write = w;
    Req_Addr  = a;
    Req_Len   = l;
    tick();
    Req_Valid = 1'b0;
    check("busy_after_accept", Busy, 1);
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic [7:0] exp_addr, input bit spur);
    int n, bad, twr;
    n = 0;
    while (!Wr_Ready && n < 200) begin
      tick();
      n++;
    end
    check("wr_ready_rise", Wr_Ready, 1);
    check("start_idle_in_wait", Start_Sig, IIC_OP_IDLE);
    Wr_Data  = d;
    Wr_Valid = 1'b1;
    tick();
    Wr_Valid = 1'b0;
    Wr_Data  = 8'h00;
    check("wr_issue_start", Start_Sig, IIC_OP_WR);
    check("wr_issue_addr", Addr_Sig, exp_addr);
    check("wr_issue_data", WrData, d);
    bad = 0;
    n = 0;
    while (!Done_Sig && n < 100) begin
      if (Start_Sig !== IIC_OP_WR || Addr_Sig !== exp_addr || WrData !== d) bad++;
      tick();
      n++;
    end
    check("wr_done_seen", Done_Sig, 1);
    check("wr_issue_unstable_cycles", bad, 0);
    tick();
    twr = 0;
    while (dbg_state == ST_WR_TWR && Start_Sig == IIC_OP_IDLE && twr < 100) begin
      if (spur && twr == 5) begin
        spur_done = 1'b1;
        Req_Valid = 1'b1;
        Req_Write = 1'b0;
        Req_Addr  = 8'h80;
        Req_Len   = 8'h00;
      end
      tick();
      spur_done = 1'b0;
      Req_Valid = 1'b0;
      twr++;
    end
    check("twr_gap_cycles", twr, 16);
  endtask

  task automatic wait_xfer(input int max);
    int n;
    n = 0;
    while (!Xfer_Done && n < max) begin
      tick();
      n++;
    end
    check("xfer_done_seen", Xfer_Done, 1);
  endtask

  task automatic compare_rd(input string tag);
    logic [7:0] e, a;
    check({tag, "_count"}, rd_q.size(), exp_q.size());
    while (exp_q.size() > 0 && rd_q.size() > 0) begin
      e = exp_q.pop_front();
      a = rd_q.pop_front();
      check(tag, a, e);
    end
  endtask

  // directed sequence
  initial begin
    int n, bad;
    logic [7:0] exp_a[3];
    RST = 1'b1;
    Req_Valid = 1'b0; Req_Write = 1'b0; Req_Addr = 8'h00; Req_Len = 8'h00;
    Wr_Data = 8'h00; Wr_Valid = 1'b0;
    repeat (3) tick();
    check("rst_start", Start_Sig, IIC_OP_IDLE);
    check("rst_busy", Busy, 0);
    check("rst_req_ready", Req_Ready, 1);
    check("rst_wr_ready", Wr_Ready, 0);
    check("rst_rd_valid", Rd_Valid, 0);
    check("rst_rd_data", Rd_Data, 8'h00);
    check("rst_addr_sig", Addr_Sig, 8'h00);
    check("rst_xfer_done", Xfer_Done, 0);
    RST = 1'b0;
    tick();

    // reset held for 3 cycles in the middle of a read
    clear_log();
    send_req(1'b0, 8'h05, 8'd3);
    repeat (10) tick();
    check("midread_start_rd", Start_Sig, IIC_OP_RD);
    RST = 1'b1;
    tick();
    check("midread_rst_start", Start_Sig, IIC_OP_IDLE);
    check("midread_rst_busy", Busy, 0);
    repeat (2) tick();
    RST = 1'b0;
    check("midread_req_ready", Req_Ready, 1);
    check("midread_rd_valid", Rd_Valid, 0);
    check("midread_xfer_done", Xfer_Done, 0);
    check("midread_state", dbg_state, ST_IDLE);
    repeat (5) tick();
    check("midread_no_done", xd_cnt, 0);
    check("midread_no_rd", rv_cnt, 0);

    // single write, addr 00, data 12
    clear_log();
    send_req(1'b1, 8'h00, 8'd0);
    wr_byte(8'h12, 8'h00, 1'b0);
    check("sw_state_done", dbg_state, ST_DONE);
    check("sw_xd_low_in_done", Xfer_Done, 0);
    tick();
    check("sw_xfer_done", Xfer_Done, 1);
    check("sw_req_ready", Req_Ready, 1);
    check("sw_busy", Busy, 0);
    tick();
    check("sw_xfer_done_drop", Xfer_Done, 0);
    check("sw_ops", op_cnt, 1);
    check("sw_xd_cnt", xd_cnt, 1);

    // wrapping 3-byte read from FE
    clear_log();
    exp_q.push_back(8'h5B);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hA5);
    send_req(1'b0, 8'hFE, 8'd2);
    wait_xfer(400);
    tick();
    exp_a = '{8'hFE, 8'hFF, 8'h00};
    check("wr_rd_ops", op_cnt, 3);
    check("wrap_addr_count", addr_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < addr_q.size()) check("wrap_addr", addr_q[i], exp_a[i]);
    end
    check("wrap_rv_cnt", rv_cnt, 3);
    compare_rd("wrap_rd_data");
    check("wrap_xd_cnt", xd_cnt, 1);

    // single-byte read: Rd_Valid leads Xfer_Done by 2 cycles
    clear_log();
    exp_q.push_back(8'h96);
    send_req(1'b0, 8'h33, 8'd0);
    wait_xfer(200);
    tick();
    compare_rd("one_rd_data");
    check("one_rd_valid_to_done", last_xd - last_rv, 2);

    // stalled write burst at 10
    clear_log();
    send_req(1'b1, 8'h10, 8'd1);
    wr_byte(8'hAA, 8'h10, 1'b0);
    check("stall_wr_ready", Wr_Ready, 1);
    bad = 0;
    repeat (40) begin
      if (Start_Sig !== IIC_OP_IDLE || Wr_Ready !== 1'b1) bad++;
      tick();
    end
    check("stall_bad_cycles", bad, 0);
    wr_byte(8'h55, 8'h11, 1'b0);
    wait_xfer(50);
    tick();
    check("stall_ops", op_cnt, 2);
    check("stall_addr0", addr_q[0], 8'h10);
    check("stall_addr1", addr_q[1], 8'h11);
    check("stall_wd0", wd_q[0], 8'hAA);
    check("stall_wd1", wd_q[1], 8'h55);
    check("stall_xd_cnt", xd_cnt, 1);

    // spurious Done_Sig in IDLE and WR_TWR, Req_Valid while busy
    clear_log();
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    check("spur_idle_state", dbg_state, ST_IDLE);
    check("spur_idle_start", Start_Sig, IIC_OP_IDLE);
    check("spur_idle_busy", Busy, 0);
    send_req(1'b1, 8'h20, 8'd0);
    wr_byte(8'h77, 8'h20, 1'b1);
    wait_xfer(50);
    repeat (30) tick();
    check("spur_busy_after", Busy, 0);
    check("spur_ops", op_cnt, 1);
    check("spur_addr", addr_q[0], 8'h20);
    check("spur_xd_cnt", xd_cnt, 1);

    // reset on cycle 8 of the write-cycle wait
    clear_log();
    send_req(1'b1, 8'h30, 8'd0);
    n = 0;
    while (!Wr_Ready && n < 200) begin tick(); n++; end
    Wr_Data = 8'h3C;
    Wr_Valid = 1'b1;
    tick();
    Wr_Valid = 1'b0;
    n = 0;
    while (!Done_Sig && n < 100) begin tick(); n++; end
    check("rtwr_done_seen", Done_Sig, 1);
    tick();
    repeat (7) tick();
    check("rtwr_in_twr", dbg_state, ST_WR_TWR);
    RST = 1'b1;
    tick();
    check("rtwr_start", Start_Sig, IIC_OP_IDLE);
    check("rtwr_busy", Busy, 0);
    check("rtwr_state", dbg_state, ST_IDLE);
    RST = 1'b0;
    repeat (20) tick();
    check("rtwr_no_done", xd_cnt, 0);
    exp_q.push_back(8'hE5);
    send_req(1'b0, 8'h40, 8'd0);
    wait_xfer(200);
    tick();
    compare_rd("rtwr_after_rd");
    check("rtwr_after_xd", xd_cnt, 1);
    check("no_double_pulses", dbl_cnt, 0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eeprom_xfer_ctrl.md
Name: eeprom_xfer_ctrl

Overview:
- Upstream command sequencer for the iic_com byte engine. Turns a multi-byte read or write request (start address, length) into a sequence of single-byte iic_com operations.
- Sequences the Start_Sig/Done_Sig handshake and inserts the EEPROM internal write-cycle delay (tWR) after every byte write.
- Streams read bytes out on a valid strobe. Replaces hand-coded step sequencing in top-level test logic.

Parameters:
- TWR_CYCLES, 250000, clocks to wait after each byte write (5 ms at 50 MHz); must be ≥1.
- LEN_W, 8, width of the request length field.

Ports:
- CLK  in  1  system clock; same clock as iic_com.
- RST  in  1  synchronous, active-high reset.
- Req_Valid  in  1  request strobe.
- Req_Ready  out  1  high in IDLE only; request accepted on Req_Valid && Req_Ready.
- Req_Write  in  1  1 = write burst, 0 = read burst.
- Req_Addr  in  8  start byte address.
- Req_Len  in  LEN_W  byte count minus 1 (0 → 1 byte).
- Wr_Data  in  8  write byte.
- Wr_Valid  in  1  write byte available.
- Wr_Ready  out  1  high only in WAIT_WDATA; byte taken on Wr_Valid && Wr_Ready.
- Rd_Data  out  8  read byte; held until the next read completes.
- Rd_Valid  out  1  one-cycle pulse per read byte; no backpressure.
- Busy  out  1  high whenever state ≠ IDLE.
- Xfer_Done  out  1  one-cycle pulse at burst end.
- Start_Sig  out  2  to iic_com: 00 idle, 01 write, 10 read.
- Addr_Sig  out  8  to iic_com byte address.
- WrData  out  8  to iic_com write byte.
- RdData  in  8  from iic_com read byte.
- Done_Sig  in  1  from iic_com op-complete.

Behaviour:
- Reset (RST high at a CLK edge): state=IDLE; Start_Sig=00; Addr_Sig=00; WrData=00; Rd_Data=00; Rd_Valid=0; Xfer_Done=0; Busy=0; Wr_Ready=0; all counters 0.
- Reset mid-operation aborts immediately, with no Xfer_Done. iic_com must share RST so it also aborts.
- All outputs are registered.
- FSM:
  - IDLE: on accept, latch addr←Req_Addr, cnt←Req_Len, dir←Req_Write. Go to WAIT_WDATA (write) or RD_ISSUE (read).
  - WAIT_WDATA: Wr_Ready=1. On Wr_Valid, latch the byte into WrData, set Addr_Sig=addr, Start_Sig=01, go to WR_ISSUE. A stall of any length is allowed; Start_Sig stays 00 throughout.
  - WR_ISSUE: hold Start_Sig=01, Addr_Sig and WrData stable until Done_Sig. On Done_Sig: Start_Sig←00, load tWR counter with TWR_CYCLES-1, go to WR_TWR.
  - WR_TWR: Start_Sig=00; decrement the counter each cycle. When the counter is 0:
    - if cnt==0, go to DONE;
    - else addr←addr+1 (mod 256), cnt←cnt-1, go to WAIT_WDATA.
    - Total Start_Sig=00 gap after Done_Sig is exactly TWR_CYCLES cycles before Wr_Ready rises.
  - RD_ISSUE: Start_Sig=10, Addr_Sig=addr, held until Done_Sig. On Done_Sig: Rd_Data←RdData, Rd_Valid←1 (next cycle, one cycle only), Start_Sig←00, go to RD_GAP.
  - RD_GAP: one cycle with Start_Sig=00, which iic_com needs to return to idle.
    - if cnt==0, go to DONE;
    - else addr++, cnt--, Start_Sig←10, go to RD_ISSUE.
  - DONE: Xfer_Done=1 for one cycle, then IDLE.
- Done_Sig is honoured only in WR_ISSUE and RD_ISSUE; it is ignored in all other states.
- Address wraps 0xFF→0x00 (256-byte device); no page logic (single-byte writes only).
- Length is 1..2^LEN_W bytes; cnt is never decremented below 0.
- Req_Valid while Busy is not accepted and has no effect.
- Rd_Valid and Xfer_Done are never high for more than one consecutive cycle.
- For a 1-byte read, Rd_Valid precedes Xfer_Done by 2 cycles.

Decomposition:
- Shared package/include eeprom_pkg:
  - IIC_OP_IDLE=2'b00, IIC_OP_WR=2'b01, IIC_OP_RD=2'b10;
  - FSM state encodings;
  - default TWR_CYCLES.
- One sub-module: eeprom_twr_timer, a loadable down-counter with a load input and zero flag, width $clog2(TWR_CYCLES).

Test Plan (TWR_CYCLES=16; iic_com replaced by a model that asserts Done_Sig 1 cycle, 20 cycles after Start_Sig≠00, returning RdData=addr^8'hA5):
- Reset: hold RST 3 cycles while mid-read → Start_Sig=00, Busy=0, Rd_Valid=0, Xfer_Done=0, Req_Ready=1.
- Single write: Req_Write=1, Addr=00, Len=0, Wr_Data=12 → Start_Sig=01/Addr_Sig=00/WrData=12 until Done_Sig; then exactly 16 cycles of Start_Sig=00; then one Xfer_Done pulse and Req_Ready=1.
- Wrapping read: Addr=FE, Len=2 → Addr_Sig sequence FE, FF, 00; Rd_Valid 3 pulses with Rd_Data 5B, 5A, A5; ≥1 Start_Sig=00 cycle between ops; one Xfer_Done.
- Stalled write burst: Addr=10, Len=1, second Wr_Valid delayed 40 cycles → Start_Sig stays 00 throughout the stall; second op uses Addr_Sig=11 with the correct byte.
- Spurious inputs: Done_Sig pulsed in IDLE and WR_TWR, and Req_Valid pulsed while Busy → no state change, no extra Start_Sig, no extra Xfer_Done; second request not accepted.
- Reset during WR_TWR (cycle 8 of 16) → Start_Sig=00 and Busy=0 on the next edge, no Xfer_Done; a new request afterwards completes normally.
